debouncer: RTL and testbench

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 83 ++++++++
 tb/tb_debouncer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Switch debouncer: synchronises a raw asynchronous level, then only accepts a change
// once it has been observed for stable_tick_count consecutive edges; emits edge strobes.
module debouncer #(
    parameter int unsigned stable_tick_count   = 16,
    parameter int unsigned synchronizer_stages = 2,
    parameter bit          reset_level         = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic original_signal,
    output logic debounced_signal,
    output logic rising_pulse,
    output logic falling_pulse,
    output logic settling
);

    localparam int unsigned count_width = $clog2(stable_tick_count + 1);
    localparam logic [count_width-1:0] count_target = count_width'(stable_tick_count);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_t;

    logic [synchronizer_stages-1:0] sync_q;
    logic                           sync_level;
    state_t                         state_q, state_d;
    logic [count_width-1:0]         count_q, count_d, next_count;
    logic                           debounced_d, rising_d, falling_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {synchronizer_stages{reset_level}};
        end else begin
            sync_q <= {sync_q[synchronizer_stages-2:0], original_signal};
        end
    end

    assign sync_level = sync_q[synchronizer_stages-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= STABLE;
            count_q          <= '0;
            debounced_signal <= reset_level;
            rising_pulse     <= 1'b0;
            falling_pulse    <= 1'b0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            debounced_signal <= debounced_d;
            rising_pulse     <= rising_d;
            falling_pulse    <= falling_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_count  = count_q + count_width'(1);
        state_d     = STABLE;
        count_d     = '0;
        debounced_d = debounced_signal;
        rising_d    = 1'b0;
        falling_d   = 1'b0;

        // Both states react identically; a matching level always collapses back to STABLE,
        // which discards a half-timed candidate without touching the output.
        if (sync_level != debounced_signal) begin
            if (next_count == count_target) begin
                debounced_d = ~debounced_signal;
                rising_d    = ~debounced_signal;
                falling_d   = debounced_signal;
            end else begin
                state_d = SETTLING;
                count_d = next_count;
            end
        end
    end

    assign settling = (state_q == SETTLING);

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer: a 4-tick and a 1-tick instance share one raw input; a behavioural
// model fills a scoreboard per edge, and directed edge-indexed checks pin the key timings.
module tb_debouncer;

    typedef struct packed {
        logic deb;
        logic rise;
        logic fall;
        logic sett;
    } out_t;

    typedef struct packed {
        out_t a;
        out_t b;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic raw     = 1'b0;
    logic deb_a, rise_a, fall_a, sett_a;
    logic deb_b, rise_b, fall_b, sett_b;

    debouncer #(.stable_tick_count(4), .synchronizer_stages(2), .reset_level(1'b0)) dut_a (
        .clock(clock), .reset_n(reset_n), .original_signal(raw),
        .debounced_signal(deb_a), .rising_pulse(rise_a), .falling_pulse(fall_a), .settling(sett_a)
    );

    debouncer #(.stable_tick_count(1), .synchronizer_stages(2), .reset_level(1'b0)) dut_b (
        .clock(clock), .reset_n(reset_n), .original_signal(raw),
        .debounced_signal(deb_b), .rising_pulse(rise_b), .falling_pulse(fall_b), .settling(sett_b)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    logic [1:0] m_sync [2];
    logic       m_deb  [2];
    int         m_run  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sync[i] = '0;
            m_deb[i]  = 1'b0;
            m_run[i]  = 0;
        end
        exp_q.delete();
    endtask

    // Run-length view: the output flips once the synchronised level has disagreed for
    // 'ticks' edges in a row; any agreeing edge restarts the run.
    task automatic model_step(input int i, input int ticks, input logic r, output out_t o);
        logic s;
        s = m_sync[i][1];
        o = '0;
        if (s != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == ticks) begin
                m_deb[i] = ~m_deb[i];
                o.rise   = m_deb[i];
                o.fall   = ~m_deb[i];
                m_run[i] = 0;
            end
        end else begin
            m_run[i] = 0;
        end
        m_sync[i] = {m_sync[i][0], r};
        o.deb  = m_deb[i];
        o.sett = (m_run[i] != 0);
    endtask

    task automatic predict();
        out_t oa, ob;
        model_step(0, 4, raw, oa);
        model_step(1, 1, raw, ob);
        exp_q.push_back({oa, ob});
    endtask

    task automatic compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("sb_a", {28'd0, deb_a, rise_a, fall_a, sett_a}, {28'd0, e.a});
        check("sb_b", {28'd0, deb_b, rise_b, fall_b, sett_b}, {28'd0, e.b});
        check("strobe_excl_a", {31'd0, rise_a & fall_a}, 32'd0);
    endtask

    task automatic cycle(input logic r);
        raw = r;
        predict();
        @(posedge clock);
        #1;
        compare();
    endtask

    task automatic check_zero(input string tag);
        check(tag, {24'd0, deb_a, rise_a, fall_a, sett_a, deb_b, rise_b, fall_b, sett_b}, 32'd0);
    endtask

    task automatic do_reset(input logic r, input int edges);
        raw     = r;
        reset_n = 1'b0;
        #1;
        check_zero("reset_async");
        model_reset();
        repeat (edges) begin
            @(posedge clock);
            #1;
            check_zero("reset_held");
        end
        reset_n = 1'b1;
    endtask

    initial begin
        logic       hist [64];
        logic       r;
        logic [6:0] pattern;

        // Raw high through reset, then release: rise lands on edge 6
        do_reset(1'b1, 3);
        for (int e = 1; e <= 8; e++) begin
            cycle(1'b1);
            check("r026_deb",  {31'd0, deb_a},  {31'd0, e >= 6});
            check("r026_rise", {31'd0, rise_a}, {31'd0, e == 6});
            check("r026_sett", {31'd0, sett_a}, {31'd0, e >= 3 && e <= 5});
        end

        // Drop and hold low: falling strobe six edges after the drop
        for (int e = 1; e <= 8; e++) begin
            cycle(1'b0);
            check("r029_deb",  {31'd0, deb_a},  {31'd0, e < 6});
            check("r029_fall", {31'd0, fall_a}, {31'd0, e == 6});
        end

        // Three-cycle glitch never reaches the output
        for (int e = 1; e <= 11; e++) begin
            cycle(e <= 3);
            check("r027_deb",  {31'd0, deb_a}, 32'd0);
            check("r027_strb", {30'd0, rise_a, fall_a}, 32'd0);
            check("r027_sett", {31'd0, sett_a}, {31'd0, e >= 3 && e <= 5});
        end

        // 1,1,0,1,1,1,1: the 0 restarts the count, rise on edge 9
        pattern = 7'b1111011;
        for (int e = 1; e <= 10; e++) begin
            cycle((e <= 7) ? pattern[e-1] : 1'b1);
            check("r028_deb",  {31'd0, deb_a},  {31'd0, e >= 9});
            check("r028_rise", {31'd0, rise_a}, {31'd0, e == 9});
        end
        repeat (8) cycle(1'b0);

        // Reset while count = 3 abandons the change; a full count is needed afterwards
        for (int e = 1; e <= 5; e++) cycle(1'b1);
        check("r030_pre_sett", {31'd0, sett_a}, 32'd1);
        do_reset(1'b1, 2);
        for (int e = 1; e <= 8; e++) begin
            cycle(1'b1);
            check("r030_deb",  {31'd0, deb_a},  {31'd0, e >= 6});
            check("r030_rise", {31'd0, rise_a}, {31'd0, e == 6});
        end

        // Toggle every 4 cycles: the 1-tick instance follows with two edges of latency
        for (int e = 1; e <= 40; e++) begin
            r = ((e - 1) / 4) % 2 == 0 ? 1'b0 : 1'b1;
            hist[e] = r;
            cycle(r);
            if (e >= 3) check("r031_deb_b", {31'd0, deb_b}, {31'd0, hist[e-2]});
            check("r031_sett_b", {31'd0, sett_b}, 32'd0);
        end

        // Random bursts of run length 1..8, scoreboard only
        r = 1'b0;
        for (int k = 0; k < 40; k++) begin
            r = ~r;
            repeat ($urandom_range(1, 8)) cycle(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
